// File: rtl/buff_sched_if.sv
// Handshake/status bundle between the frame scheduler and its environment.
// The scheduler sits on the slave side; the producer/consumer side drives master.
interface buff_sched_if #(
  parameter int SIZE  = 64,
  parameter int FRAME = 16
);
  localparam int DEPTH = SIZE / FRAME;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          in_start;
  logic          out_ready;
  logic          clear_err;
  logic          wr_toggle;
  logic          rd_toggle;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic [CW-1:0] frames_avail;
  logic          full;
  logic          empty;
  logic          err_overflow;

  modport master (
    output in_start, out_ready, clear_err,
    input  wr_toggle, rd_toggle, out_valid, out_first, out_last,
           frames_avail, full, empty, err_overflow
  );

  modport slave (
    input  in_start, out_ready, clear_err,
    output wr_toggle, rd_toggle, out_valid, out_first, out_last,
           frames_avail, full, empty, err_overflow
  );
endinterface

// File: rtl/buff_sched.sv
// Frame scheduler for a toggle-controlled circular buffer.
// The buffer is split into DEPTH frame slots. A write burst reserves a slot at
// its start and commits it after its last word; a read burst releases the slot
// after its last word. Toggles bracket each burst: one on the first cycle and
// one on the last, so the buffer enable is active for exactly FRAME cycles.
module buff_sched #(
  parameter  int SIZE   = 64,
  parameter  int FRAME  = 16,
  parameter  int RD_LAT = 1,
  localparam int DEPTH  = SIZE / FRAME,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  buff_sched_if.slave    bus
);

  localparam int FW = $clog2(FRAME);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [FW-1:0] FRAME_M1_C = FW'(FRAME - 1);

  // Tag carried alongside each read-enabled cycle until data_out is valid.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } rd_tag_t;

  logic          wr_busy_q, wr_busy_d;
  logic [FW-1:0] wcnt_q,    wcnt_d;
  logic          rd_busy_q, rd_busy_d;
  logic [FW-1:0] rcnt_q,    rcnt_d;
  logic [CW-1:0] slots_q,   slots_d;
  logic [CW-1:0] avail_q,   avail_d;
  logic          err_q,     err_d;
  rd_tag_t       vld_pipe_q [RD_LAT];
  rd_tag_t       tag_in;

  logic accept, reject, wr_last;
  logic rd_start, rd_last, rd_en;

  // Burst events, all derived from registered state only (no release bypass).
  assign accept   = bus.in_start & ~wr_busy_q & (slots_q < DEPTH_C);
  assign reject   = bus.in_start & ~accept;
  assign wr_last  = wr_busy_q & (wcnt_q == FRAME_M1_C);
  assign rd_start = ~rd_busy_q & (avail_q != '0) & bus.out_ready;
  assign rd_last  = rd_busy_q & (rcnt_q == FRAME_M1_C);
  assign rd_en    = rd_start | rd_busy_q;

  // Write burst counter: wcnt counts words 1..FRAME-1 after the start cycle.
  always_comb begin
    wr_busy_d = wr_busy_q;
    wcnt_d    = wcnt_q;
    if (accept) begin
      wr_busy_d = 1'b1;
      wcnt_d    = FW'(1);
    end else if (wr_last) begin
      wr_busy_d = 1'b0;
      wcnt_d    = '0;
    end else if (wr_busy_q) begin
      wcnt_d    = wcnt_q + FW'(1);
    end
  end

  // Read burst counter, mirror of the write side; out_ready only matters at launch.
  always_comb begin
    rd_busy_d = rd_busy_q;
    rcnt_d    = rcnt_q;
    if (rd_start) begin
      rd_busy_d = 1'b1;
      rcnt_d    = FW'(1);
    end else if (rd_last) begin
      rd_busy_d = 1'b0;
      rcnt_d    = '0;
    end else if (rd_busy_q) begin
      rcnt_d    = rcnt_q + FW'(1);
    end
  end

  // Slot accounting; coincident +1/-1 events cancel naturally.
  always_comb begin
    slots_d = slots_q + CW'(accept) - CW'(rd_last);
    avail_d = avail_q + CW'(wr_last) - CW'(rd_start);
    err_d   = err_q;
    if (reject)             err_d = 1'b1;
    else if (bus.clear_err) err_d = 1'b0;
  end

  // Tag for the current read-enabled cycle entering the delay line.
  always_comb begin
    tag_in.vld   = rd_en;
    tag_in.first = rd_start;
    tag_in.last  = rd_last;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_busy_q <= 1'b0;
      wcnt_q    <= '0;
      rd_busy_q <= 1'b0;
      rcnt_q    <= '0;
      slots_q   <= '0;
      avail_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_busy_q <= wr_busy_d;
      wcnt_q    <= wcnt_d;
      rd_busy_q <= rd_busy_d;
      rcnt_q    <= rcnt_d;
      slots_q   <= slots_d;
      avail_q   <= avail_d;
      err_q     <= err_d;
    end
  end

  // RD_LAT-deep delay line aligning qualifiers with buffer data_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) vld_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign bus.wr_toggle    = accept | wr_last;
  assign bus.rd_toggle    = rd_start | rd_last;
  assign bus.out_valid    = vld_pipe_q[RD_LAT-1].vld;
  assign bus.out_first    = vld_pipe_q[RD_LAT-1].vld & vld_pipe_q[RD_LAT-1].first;
  assign bus.out_last     = vld_pipe_q[RD_LAT-1].vld & vld_pipe_q[RD_LAT-1].last;
  assign bus.frames_avail = avail_q;
  assign bus.full         = (slots_q == DEPTH_C);
  assign bus.empty        = (slots_q == '0);
  assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_buff_sched.sv
// Directed bench for buff_sched with a behavioural toggle buffer attached,
// so frame data can be followed from data_in to data_out.
module tb_buff_sched;
  localparam int SIZE  = 64;
  localparam int FRAME = 16;
  localparam int AW    = $clog2(SIZE);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data_in = '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  buff_sched_if #(.SIZE(SIZE), .FRAME(FRAME)) bus ();

  buff_sched #(.SIZE(SIZE), .FRAME(FRAME), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Toggle-controlled circular buffer: enable active on toggle cycle and while held.
  logic [7:0]    mem [SIZE];
  logic [AW-1:0] wptr, rptr;
  logic          wen_q, ren_q;
  logic [7:0]    dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      dout  <= '0;
    end else begin
      if (wen_q | bus.wr_toggle) begin
        mem[wptr] <= data_in;
        wptr      <= wptr + 1'b1;
      end
      if (ren_q | bus.rd_toggle) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      wen_q <= wen_q ^ bus.wr_toggle;
      ren_q <= ren_q ^ bus.rd_toggle;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_start  = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear_err = 1'b0;
    data_in       = '0;
  endtask

  // Hold reset for two edges, release, check reset values, land at cycle 0 (+1).
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    cyc = -1;
    chk("rst.wr_tog", bus.wr_toggle,    0);
    chk("rst.rd_tog", bus.rd_toggle,    0);
    chk("rst.valid",  bus.out_valid,    0);
    chk("rst.avail",  bus.frames_avail, 0);
    chk("rst.full",   bus.full,         0);
    chk("rst.empty",  bus.empty,        1);
    chk("rst.err",    bus.err_overflow, 0);
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // One frame in at cycle 10, read straight back with out_ready held high.
  task automatic run_single();
    for (int c = 0; c <= 44; c++) begin
      cyc = c;
      bus.in_start  = (c == 10);
      bus.out_ready = 1'b1;
      bus.clear_err = 1'b0;
      data_in       = 8'(c - 10);
      #4;
      chk("A.wr_tog", bus.wr_toggle,    (c == 10 || c == 25));
      chk("A.rd_tog", bus.rd_toggle,    (c == 26 || c == 41));
      chk("A.avail",  bus.frames_avail, (c == 26));
      chk("A.valid",  bus.out_valid,    (c >= 27 && c <= 42));
      chk("A.first",  bus.out_first,    (c == 27));
      chk("A.last",   bus.out_last,     (c == 42));
      chk("A.empty",  bus.empty,        !(c >= 11 && c <= 41));
      if (c >= 27 && c <= 42) chk("A.data", dout, c - 27);
      next_cycle();
    end
  endtask

  initial begin
    idle_inputs();

    do_reset();
    run_single();

    // Fill with out_ready low, overflow, clear, then drain while writing at full.
    do_reset();
    for (int c = 0; c <= 120; c++) begin
      cyc = c;
      bus.in_start  = (c inside {0, 16, 32, 48, 64, 115, 116});
      bus.out_ready = (c >= 100);
      bus.clear_err = (c == 90);
      data_in       = 8'(c);
      #4;
      chk("B.wr_tog", bus.wr_toggle, (c inside {0, 15, 16, 31, 32, 47, 48, 63, 116}));
      chk("B.rd_tog", bus.rd_toggle, (c inside {100, 115, 116}));
      chk("B.full",   bus.full,      ((c >= 49 && c <= 115) || c >= 117));
      chk("B.empty",  bus.empty,     (c == 0));
      chk("B.err",    bus.err_overflow, ((c >= 65 && c <= 90) || c >= 116));
      if (c <= 100)
        chk("B.avail", bus.frames_avail, (c >= 16) + (c >= 32) + (c >= 48) + (c >= 64));
      else
        chk("B.avail", bus.frames_avail, (c <= 116) ? 3 : 2);
      chk("B.valid",  bus.out_valid, (c >= 101));
      chk("B.first",  bus.out_first, (c == 101 || c == 117));
      chk("B.last",   bus.out_last,  (c == 116));
      if (c >= 101) chk("B.data", dout, (c <= 116) ? c - 101 : c - 117 + 16);
      next_cycle();
    end

    // Second in_start overlaps the first burst and is rejected.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      cyc = c;
      bus.in_start  = (c == 0 || c == 5);
      bus.out_ready = 1'b0;
      bus.clear_err = (c == 20);
      data_in       = 8'(c);
      #4;
      chk("C.wr_tog", bus.wr_toggle,    (c == 0 || c == 15));
      chk("C.err",    bus.err_overflow, (c >= 6 && c <= 20));
      chk("C.avail",  bus.frames_avail, (c >= 16));
      next_cycle();
    end

    // Read launches on the cycle the second write's last word lands.
    do_reset();
    for (int c = 0; c <= 65; c++) begin
      cyc = c;
      bus.in_start  = (c == 0 || c == 16);
      bus.out_ready = (c >= 31);
      bus.clear_err = 1'b0;
      data_in       = 8'(c);
      #4;
      chk("D.rd_tog", bus.rd_toggle,    (c inside {31, 46, 47, 62}));
      chk("D.avail",  bus.frames_avail, (c >= 16 && c <= 47));
      chk("D.first",  bus.out_first,    (c == 32 || c == 48));
      chk("D.last",   bus.out_last,     (c == 47 || c == 63));
      chk("D.empty",  bus.empty,        (c == 0 || c >= 63));
      if (c >= 32 && c <= 63) chk("D.data", dout, c - 32);
      next_cycle();
    end

    // Asynchronous reset in the middle of a write burst.
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      cyc = c;
      bus.in_start  = (c == 0);
      bus.out_ready = 1'b1;
      data_in       = 8'(100 + c);
      if (c < 7) begin
        #4;
        chk("E.wr_tog", bus.wr_toggle, (c == 0));
        chk("E.empty",  bus.empty,     (c == 0));
        next_cycle();
      end else begin
        #1 rst = 1'b1;
        #1;
        chk("E.rst_wr",    bus.wr_toggle,    0);
        chk("E.rst_empty", bus.empty,        1);
        chk("E.rst_avail", bus.frames_avail, 0);
        chk("E.rst_valid", bus.out_valid,    0);
      end
    end
    do_reset();
    run_single();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buff_sched.md
Name: buff_sched

Overview:
- Frame-level scheduler that drives the wr_toggle/rd_toggle pair of the toggle-controlled circular buffer, which is SIZE words deep. While a buffer enable is active, its pointer advances by one every cycle.
- Partitions the buffer into DEPTH = SIZE/FRAME frame slots.
- Admits incoming frames and tracks free and committed slots.
- Launches read bursts when the consumer is ready, and produces aligned out_valid/out_first/out_last for the buffer's data_out.

Parameters:
- SIZE, 64: buffer depth in words. Must match the buffer instance.
- FRAME, 16: words per frame. FRAME >= 2; SIZE must be a multiple of FRAME.
- RD_LAT, 1: cycles from a read-enabled cycle to valid data_out. RD_LAT >= 1.
- DEPTH, SIZE/FRAME: frame slots (derived).
- CW, $clog2(DEPTH+1): width of the slot counters (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_start  in  1  first word of an input frame on data_in this cycle; the remaining FRAME-1 words follow on consecutive cycles
- out_ready  in  1  consumer can accept a full frame; sampled only at frame-read start
- clear_err  in  1  clears err_overflow
- wr_toggle  out  1  to buffer wr_toggle
- rd_toggle  out  1  to buffer rd_toggle
- out_valid  out  1  buffer data_out holds a valid frame word
- out_first  out  1  with out_valid: word 0 of the frame
- out_last  out  1  with out_valid: word FRAME-1 of the frame
- frames_avail  out  CW  committed frames not yet started reading
- full  out  1  slots_used == DEPTH
- empty  out  1  slots_used == 0
- err_overflow  out  1  sticky: an in_start was rejected

Behaviour:
- Reset (async, rst=1): all state cleared.
  - wr_toggle=0, rd_toggle=0, out_valid/first/last=0, frames_avail=0, full=0, empty=1, err_overflow=0.
  - Delay line flushed.
  - The buffer must share the same reset, because its pointers also return to 0.
  - Reset mid-burst abandons the frame; no toggles are issued afterwards.
- State registers:
  - wr_busy, wcnt[$clog2(FRAME)]
  - rd_busy, rcnt[$clog2(FRAME)]
  - slots_used[CW]: reserved at write start, released at read end
  - frames_avail[CW]: committed frames
- Write admission, combinational: accept = in_start & ~wr_busy & (slots_used < DEPTH). Registered values only; no same-cycle bypass of a read release.
- Write burst, for accept at cycle t:
  - wr_toggle=1 at t (combinational, same cycle as in_start).
  - wr_busy set at t+1 with wcnt=1; wcnt increments each cycle.
  - wr_toggle=1 again at t+FRAME-1 (wr_busy & wcnt==FRAME-1).
  - wr_busy clears at t+FRAME. A new in_start at t+FRAME is legal (back-to-back).
- Write rejection: in_start with ~accept sets err_overflow and issues no toggle. This covers in_start while wr_busy (cycles t+1..t+FRAME-1) and in_start while full.
- clear_err: clears err_overflow next cycle; a simultaneous rejection wins (flag stays 1).
- Commit: frames_avail increments at the cycle after the write-last cycle.
- Read launch, combinational: rd_start = ~rd_busy & (frames_avail != 0) & out_ready.
  - rd_toggle=1 on rd_start at cycle r, and again at r+FRAME-1.
  - rd_busy covers r+1..r+FRAME-1; back-to-back launch is allowed at r+FRAME.
  - frames_avail decrements at r+1.
  - out_ready is ignored during a burst; there is no mid-frame backpressure.
- Counter updates when events coincide in one cycle:
  - Commit and read start together: frames_avail unchanged.
  - Write start and read end together: slots_used unchanged.
  - Read end (r+FRAME-1) decrements slots_used at r+FRAME.
- Output qualification: read-enabled cycles r..r+FRAME-1 feed an RD_LAT-stage delay line.
  - out_valid is high at r+RD_LAT..r+FRAME-1+RD_LAT.
  - out_first is high at r+RD_LAT.
  - out_last is high at r+FRAME-1+RD_LAT.
- Wrap-around: frames are contiguous and the buffer pointers wrap modulo SIZE, so slot k always maps to addresses k*FRAME..k*FRAME+FRAME-1. No address output is needed.
- Invariants: frames_avail <= slots_used <= DEPTH; full and empty are never both 1.

Test Plan:
- Single frame (SIZE=64, FRAME=16, RD_LAT=1), out_ready=1, in_start at cycle 10 with data 0..15:
  - wr_toggle at 10 and 25; frames_avail=1 at 26.
  - rd_toggle at 26 and 41; out_valid 27..42 with data 0..15; out_first at 27, out_last at 42; empty=1 at 42.
- Back-to-back writes with out_ready=0, in_start at 0, 16, 32, 48:
  - full=1 from cycle 49; frames_avail=4 at 64.
  - in_start at 64 is rejected: err_overflow=1, no wr_toggle.
- Overlapping start: in_start at 0 and at 5 → only the cycle-0 frame is accepted; err_overflow=1 from cycle 6; clear_err at 20 → err_overflow=0 at 21.
- Simultaneous events, setup: full buffer, out_ready raised at cycle 100 → rd_toggle at 100 and 115, slots_used=3 at 116.
  - in_start at 115 is rejected (full still 1 until 116).
  - in_start at 116 is accepted, with wr_toggle at 116.
- Commit/read coincidence: frames_avail=1 with a read starting at the same cycle a second write commits → frames_avail stays 1; the second read launches back-to-back at read start + 16.
- Reset mid-burst: assert rst asynchronously at cycle 7 of a write burst → all outputs at reset values immediately. A fresh in_start after release runs the single-frame scenario with its data read back in order.
